// File: rtl/div_ratio_ctrl.sv
// 50%-duty clock divider controller; o_CLK/o_TICK registered, one-cycle latency from i_CLK.
// Ratio loads use valid/ready: ready drops while a new ratio waits for a period boundary or a stop completes.
module div_ratio_ctrl #(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_HALF = 2
) (
    input  logic             i_CLK,
    input  logic             i_RST,
    input  logic             i_EN,
    input  logic [WIDTH-1:0] i_HALF,
    input  logic             i_LOAD_VALID,
    output logic             o_LOAD_READY,
    output logic             o_CLK,
    output logic             o_TICK,
    output logic [WIDTH-1:0] o_HALF_CUR,
    output logic             o_RUNNING
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] half_q, half_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    logic             xfer;
    logic             terminal;
    logic             stopping;
    logic [WIDTH-1:0] half_in;

    assign o_LOAD_READY = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign xfer         = i_LOAD_VALID && o_LOAD_READY;
    assign half_in      = (i_HALF == '0) ? WIDTH'(1) : i_HALF;
    assign terminal     = (cnt_q == half_q - WIDTH'(1));
    assign stopping     = (state_q == ST_STOP) || !i_EN;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (xfer) half_d = half_in;
                if (i_EN) state_d = ST_RUN;
            end
            ST_RUN, ST_PEND, ST_STOP: begin
                if (xfer) begin
                    pend_d     = half_in;
                    pend_vld_d = 1'b1;
                end
                if (stopping && !clk_q) begin
                    // Low half: stop at once, never emit the pending rise.
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    clk_d      = 1'b0;
                    if (pend_vld_d) half_d = pend_d;
                    pend_vld_d = 1'b0;
                end else if (terminal) begin
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    tick_d = ~clk_q;
                    if (clk_q && stopping) begin
                        state_d    = ST_IDLE;
                        if (pend_vld_d) half_d = pend_d;
                        pend_vld_d = 1'b0;
                    end else begin
                        // Falling toggle is the only point a queued ratio becomes active.
                        if (clk_q && pend_vld_q) begin
                            half_d     = pend_q;
                            pend_vld_d = 1'b0;
                        end
                        if (xfer)                    state_d = ST_PEND;
                        else if (clk_q && pend_vld_q) state_d = ST_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                    if (stopping)  state_d = ST_STOP;
                    else if (xfer) state_d = ST_PEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            half_q     <= WIDTH'(DEFAULT_HALF);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
        end
    end

    assign o_CLK      = clk_q;
    assign o_TICK     = tick_q;
    assign o_HALF_CUR = half_q;
    assign o_RUNNING  = (state_q != ST_IDLE);

endmodule

// File: doc/div_ratio_ctrl.md
Name: div_ratio_ctrl

Overview:
Run-time controller for a 50%-duty clock divider. Holds the active half-period, accepts new ratios over a valid/ready handshake and applies them only at an output-period boundary, so o_CLK never glitches. Provides glitch-free start/stop and a one-cycle tick aligned to each o_CLK rising edge. Sits between the system configuration logic and the clock-enable / slow-clock consumers (display scan, debounce, timers).

Parameters:
WIDTH, 16, width of the half-period registers and the counter.
DEFAULT_HALF, 2, active half-period after reset, in i_CLK cycles. Gives division ratio 4.

Ports:
i_CLK  input  1  system clock; all logic on its rising edge.
i_RST  input  1  asynchronous, active-high reset.
i_EN  input  1  run request; level-sensitive.
i_HALF  input  WIDTH  requested half-period in i_CLK cycles; output period = 2*i_HALF.
i_LOAD_VALID  input  1  i_HALF is valid.
o_LOAD_READY  output  1  controller can accept a ratio this cycle.
o_CLK  output  1  divided clock, registered.
o_TICK  output  1  one-cycle pulse, high in the same cycle o_CLK goes 0->1.
o_HALF_CUR  output  WIDTH  active half-period.
o_RUNNING  output  1  high in RUN, PEND and STOP.

Behaviour:
- Reset (asynchronous, any time): o_CLK=0, o_TICK=0, counter=0, o_HALF_CUR=DEFAULT_HALF, pending ratio discarded, state=IDLE, o_LOAD_READY=1, o_RUNNING=0.
- Clamp: an accepted i_HALF of 0 is stored as 1. There is no other range check.
- Handshake: a transfer occurs on a cycle with i_LOAD_VALID && o_LOAD_READY.
  - o_LOAD_READY is combinational from state: 1 in IDLE and RUN, 0 in PEND and STOP.
  - i_HALF is sampled only on the transfer cycle.
- States:
  - IDLE: o_CLK=0 and the counter is held at 0.
    - A transfer writes o_HALF_CUR on the next edge.
    - If i_EN=1, go to RUN with counter=0. If a transfer and i_EN rise happen in the same cycle, the new value governs the first period.
  - RUN: counter increments every cycle.
    - When counter==o_HALF_CUR-1: toggle o_CLK and set counter=0.
    - First rising edge of o_CLK comes o_HALF_CUR cycles after entering RUN. After that, period = 2*o_HALF_CUR and duty is exactly 50%.
    - A transfer stores the value in the pending register and moves to PEND. Counting continues unchanged.
    - If i_EN=0: with o_CLK=0, go to IDLE at once and clear the counter; with o_CLK=1, go to STOP.
  - PEND: counts exactly like RUN.
    - On the falling-toggle cycle (counter==o_HALF_CUR-1 and o_CLK=1): o_CLK<=0, counter<=0, o_HALF_CUR<=pending, go to RUN. The new ratio takes effect from the next low half; no partial period ever occurs.
    - If i_EN=0 with o_CLK=0: o_HALF_CUR<=pending and go to IDLE.
    - If i_EN=0 with o_CLK=1: go to STOP, keeping the pending value.
  - STOP: keeps counting until the high half completes.
    - On the falling toggle: o_CLK<=0, counter<=0, go to IDLE. If a pending value exists, o_HALF_CUR<=pending.
    - A re-asserted i_EN is ignored until IDLE is reached.
- o_TICK is registered and goes high exactly with the 0->1 transition of o_CLK. It never asserts in IDLE.
- Counter width is WIDTH. The maximum half-period (2^WIDTH-1) must work with no overflow.

Test Plan:
- Reset, i_EN=1, no load -> first o_CLK rise 2 cycles after RUN entry; period 4, duty 2/2; o_TICK pulses every 4 cycles; o_HALF_CUR=2.
- In IDLE, load i_HALF=5 together with i_EN rise -> o_HALF_CUR=5; first rise after 5 cycles; period 10.
- Running at half=3, load 1 mid high-half -> o_LOAD_READY=0 until the next falling toggle; current high half completes at 3 cycles; then period 2; no pulse shorter than 1 cycle or longer than 3.
- i_EN dropped one cycle into a high half (half=4) -> o_CLK stays high for the remaining 3 cycles, then 0; IDLE; o_RUNNING=0; no o_TICK afterwards.
- Load i_HALF=0 in IDLE, run -> stored as 1; o_CLK toggles every cycle (period 2).
- Assert i_RST asynchronously in PEND with pending 7 -> o_CLK=0 immediately without waiting for a clock; o_HALF_CUR=2; pending lost; after release with i_EN=1, period 4.
